grid_scan: RTL and testbench
============================

# grid_scan

Display-side consumer for the 64-bit Game-of-Life generation word produced by `dpgen` (`gout`). It latches a generation grid, double-buffers it so updates never tear a frame, and time-multiplexes it onto an 8x8 LED matrix as a one-hot row strobe plus 8 column bits. Each row is held for a programmable dwell and followed by one blanking cycle. The block sits between the generation datapath and the board's matrix pins.

## Interface
- `DWELL`, default 4: cycles each row is driven; legal range 1..255.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `grid`  in  64  generation word; `grid[8*r+c]` is the cell at row r, column c (1 = alive).
- `load`  in  1  capture request; `grid` is sampled on any edge where `load`=1.
- `enable`  in  1  scan enable; level-sensitive.
- `row`  out  8  one-hot row strobe; `row[r]`=1 drives row r; 8'h00 when idle or blanking.
- `col`  out  8  column data for the active row; `col[c]` = `buf[8*r+c]`; 8'h00 when idle or blanking.
- `busy`  out  1  high in SCAN and BLANK.
- `frame_done`  out  1  one-cycle pulse on the final blank cycle of each frame.
- `load_ack`  out  1  one-cycle pulse, the cycle after a `load` capture.

## Operation
- Storage:
  - `shadow` (64b) is written on every `load`.
  - `buf` (64b) is the displayed frame; it is copied from `shadow` only at frame start.
- Counters:
  - `r`, 3 bits, current row.
  - `d`, 8 bits, dwell count.
- All outputs are registered.
- States:
  - **IDLE**: `row`=0, `col`=0, `busy`=0. When `enable`=1: `buf`←`shadow`, `r`←0, `d`←0, go to SCAN.
  - **SCAN**:
    - `row`=1<<r and `col`=`buf[8r+7:8r]`.
    - `d` increments each cycle.
    - When `d`=DWELL-1, go to BLANK.
  - **BLANK** (1 cycle): `row`=0, `col`=0.
    - If r<7: r←r+1, `d`←0, go to SCAN.
    - If r=7: assert `frame_done`, r←0. Then, if `enable`=1, `buf`←`shadow` and go to SCAN; otherwise go to IDLE.
- Bypass: if `load`=1 on the same edge that copies `shadow` into `buf`, `buf` takes `grid` directly. The new grid is shown in that frame, with no one-frame lag.
- `enable` dropping mid-frame does not truncate the frame. The current frame completes through row 7 and its BLANK, then the block goes to IDLE.
- Consecutive `load` pulses overwrite `shadow`; last write wins. `load_ack` pulses once per captured edge.
- Reset values:
  - `row`=0, `col`=0, `busy`=0, `frame_done`=0, `load_ack`=0.
  - `shadow`=0, `buf`=0, r=0, `d`=0.
  - State IDLE.
- Reset mid-frame: all of the above hold after the next edge; scanning restarts only when `enable` is seen after reset releases.

## Timing
- Latencies:
  - `enable` sampled high in IDLE at edge N: `row`=8'h01 from edge N+1.
  - `load` at edge N: `load_ack`=1 for edge N+1 to N+2 only.
- Row period is DWELL+1 cycles (DWELL drive, 1 blank).
- Frame period is 8·(DWELL+1) cycles; with DWELL=4 that is 40 cycles.
- `frame_done` is high exactly in the BLANK cycle following row 7. The next SCAN row 0 starts on the following edge, so there is no idle gap while enabled.
- At most one bit of `row` is ever high. `row` and `col` are both zero in every BLANK cycle.
- `reset` has priority over `load` and `enable` on the same edge.

## Test plan
- **Reset**: hold `reset`=1 for 1 edge with `load`=1 and `grid`=64'hFFFF_FFFF_FFFF_FFFF.
  - All outputs are 0.
  - After release with `enable`=1, `col`=8'h00 on every row, because `shadow` was not written.
- **Single frame**: `load` `grid`=64'h8040_2010_0804_0201, then `enable`=1, DWELL=4.
  - Row r shows `row`=`col`=1<<r for 4 cycles, then 1 blank cycle.
  - `frame_done` is high at cycle 40 after the first row.
- **Tear-free update**: `load` 64'h0000_0000_0000_00FF mid-frame (during row 3) while showing 64'hFF00_0000_0000_0000.
  - Rows 3..7 of the current frame are unchanged, i.e. row 7 `col`=8'hFF.
  - The next frame shows row 0 `col`=8'hFF and row 7 `col`=8'h00.
- **Boundary bypass**: assert `load` with 64'h0000_0000_0000_0003 exactly on the `frame_done` edge.
  - The very next row 0 shows `col`=8'h03.
- **Enable drop**: deassert `enable` during row 2.
  - The frame completes through row 7 and `frame_done` pulses.
  - `busy` then goes to 0 and `row` stays 8'h00.
- **Reset mid-scan**: assert `reset` during row 5.
  - The next edge gives `row`=0, `busy`=0, `frame_done`=0.
  - Re-enabling restarts at row 0 with `col`=0, because `buf` was cleared.

Source files
------------

// File: rtl/grid_scan_if.sv
// grid_scan_if: signal bundle between the generation side and the LED matrix
// scanner.
//   grid       64  generation word, grid[8*r+c] = cell at row r, column c
//   load        1  capture request for grid
//   enable      1  scan enable (level)
//   row         8  one-hot row strobe
//   col         8  column data for the active row
//   busy        1  scanner is in SCAN or BLANK
//   frame_done  1  pulse in the blank cycle that closes a frame
//   load_ack    1  pulse the cycle after a load capture
// The master modport belongs to whoever drives grid/load/enable. The slave
// modport is the scanner itself.
interface grid_scan_if;
  logic [63:0] grid;
  logic        load;
  logic        enable;
  logic [7:0]  row;
  logic [7:0]  col;
  logic        busy;
  logic        frame_done;
  logic        load_ack;

  modport master (
    output grid, load, enable,
    input  row, col, busy, frame_done, load_ack
  );

  modport slave (
    input  grid, load, enable,
    output row, col, busy, frame_done, load_ack
  );
endinterface

// File: rtl/grid_scan.sv
// grid_scan: double-buffered 8x8 LED matrix scanner.
// A generation word is captured into a shadow register on every load. The
// displayed buffer is refreshed from the shadow only at frame start, so a
// frame never tears. Each row is driven for DWELL cycles and then blanked for
// one cycle. The frame period is 8*(DWELL+1) cycles.
//   clk    system clock, rising edge
//   reset  synchronous, active-high; has priority over load and enable
//   bus    grid_scan_if.slave (grid/load/enable in; row/col/busy/frame_done/load_ack out)
// DWELL is the number of drive cycles per row, legal range 1..255.
module grid_scan #(
  parameter int DWELL = 4
) (
  input  logic            clk,
  input  logic            reset,
  grid_scan_if.slave      bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  logic [1:0]  state, state_n;
  logic [2:0]  r, r_n;
  logic [7:0]  d, d_n;
  logic [63:0] shadow;
  logic [63:0] frame_buf, buf_n;
  logic        copy;

  // Next-state logic. The registered outputs below are derived from these
  // next-state values, so every output lines up with the state it describes.
  always_comb begin
    // NOTE: every signal written here gets a default first. A path that
    // leaves one unassigned would infer a latch.
    state_n = state;
    r_n     = r;
    d_n     = d;
    copy    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.enable) begin
          copy    = 1'b1;
          r_n     = 3'd0;
          d_n     = 8'd0;
          state_n = ST_SCAN;
        end
      end

      ST_SCAN: begin
        d_n = d + 8'd1;
        if (d == DWELL_LAST) begin
          state_n = ST_BLANK;
        end
      end

      ST_BLANK: begin
        d_n = 8'd0;
        if (r != 3'd7) begin
          r_n     = r + 3'd1;
          state_n = ST_SCAN;
        end else begin
          // End of frame. Restart immediately while enabled. Otherwise park.
          r_n = 3'd0;
          if (bus.enable) begin
            copy    = 1'b1;
            state_n = ST_SCAN;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
        r_n     = 3'd0;
        d_n     = 8'd0;
      end
    endcase

    // A load on the frame-start edge bypasses the shadow. The new grid then
    // appears in this frame rather than one frame late.
    buf_n = frame_buf;
    if (copy) begin
      buf_n = bus.load ? bus.grid : shadow;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples the pre-edge values regardless of statement order.
    if (reset) begin
      state          <= ST_IDLE;
      r              <= 3'd0;
      d              <= 8'd0;
      shadow         <= 64'd0;
      frame_buf      <= 64'd0;
      bus.row        <= 8'h00;
      bus.col        <= 8'h00;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.load_ack   <= 1'b0;
    end else begin
      state     <= state_n;
      r         <= r_n;
      d         <= d_n;
      frame_buf <= buf_n;
      if (bus.load) begin
        shadow <= bus.grid;
      end

      bus.load_ack   <= bus.load;
      bus.busy       <= (state_n != ST_IDLE);
      bus.frame_done <= (state_n == ST_BLANK) && (r_n == 3'd7);
      if (state_n == ST_SCAN) begin
        bus.row <= 8'd1 << r_n;
        bus.col <= buf_n[{r_n, 3'b000} +: 8];
      end else begin
        bus.row <= 8'h00;
        bus.col <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_grid_scan.sv
// Testbench for grid_scan (DWELL=4). The bench applies a table of per-cycle
// vectors, then hand-written multi-cycle sequences, then random stimulus.
// Every cycle is also compared against a frame-position reference model.
module tb_grid_scan;

  localparam int DWELL   = 4;
  localparam int ROW_P   = DWELL + 1;
  localparam int FRAME_P = 8 * ROW_P;

  logic clk = 1'b0;
  logic reset;

  grid_scan_if bus_i ();

  grid_scan #(.DWELL(DWELL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_i)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model. The scanner is either idle or at position m_p within a
  // frame of FRAME_P cycles. Row and blanking follow from plain arithmetic.
  bit          m_active = 1'b0;
  int          m_p      = 0;
  logic [63:0] m_shadow = 64'd0;
  logic [63:0] m_disp   = 64'd0;
  bit          m_ack    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ld, input logic en, input logic [63:0] g);
    reset         = rst;
    bus_i.load    = ld;
    bus_i.enable  = en;
    bus_i.grid    = g;
  endtask

  task automatic model_edge();
    bit copy;
    copy = 1'b0;
    if (reset) begin
      m_active = 1'b0;
      m_p      = 0;
      m_shadow = 64'd0;
      m_disp   = 64'd0;
      m_ack    = 1'b0;
    end else begin
      if (!m_active) begin
        if (bus_i.enable) begin
          m_active = 1'b1;
          m_p      = 0;
          copy     = 1'b1;
        end
      end else if (m_p == FRAME_P - 1) begin
        if (bus_i.enable) begin
          m_p  = 0;
          copy = 1'b1;
        end else begin
          m_active = 1'b0;
        end
      end else begin
        m_p++;
      end
      if (copy) m_disp = bus_i.load ? bus_i.grid : m_shadow;
      if (bus_i.load) m_shadow = bus_i.grid;
      m_ack = bus_i.load;
    end
  endtask

  // Advance one clock and compare all outputs against the model at the falling edge.
  task automatic step();
    int       rr;
    bit       drv;
    logic [7:0] e_row, e_col;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    rr    = m_p / ROW_P;
    drv   = m_active && ((m_p % ROW_P) < DWELL);
    e_row = drv ? (8'd1 << rr) : 8'h00;
    e_col = drv ? m_disp[8*rr +: 8] : 8'h00;
    check("model_row", bus_i.row, e_row);
    check("model_col", bus_i.col, e_col);
    check("model_busy", bus_i.busy, m_active);
    check("model_frame_done", bus_i.frame_done, m_active && (m_p == FRAME_P - 1));
    check("model_load_ack", bus_i.load_ack, m_ack);
    check("row_onehot", ($countones(bus_i.row) <= 1), 1'b1);
  endtask

  typedef struct {
    logic        rst, ld, en;
    logic [63:0] g;
    logic [7:0]  row, col;
    logic        busy, fd, ack;
  } vec_t;

  localparam logic [63:0] DIAG = 64'h8040_2010_0804_0201;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  vec_t tbl [13];
  logic en_r;
  logic [7:0] e;

  initial begin
    //           rst   ld    en    grid   row    col    busy  fd    ack
    tbl[0]  = '{1'b1, 1'b1, 1'b0, ONES,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 64'd0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 64'd0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 64'd0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 64'd0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 64'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 64'd0, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, ONES,  8'h02, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 64'd0, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 64'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 64'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, DIAG,  8'h01, 8'h01, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 64'd0, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0};

    drive(1'b1, 1'b1, 1'b0, ONES);
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst, tbl[i].ld, tbl[i].en, tbl[i].g);
      step();
      check($sformatf("tbl%0d_row", i), bus_i.row, tbl[i].row);
      check($sformatf("tbl%0d_col", i), bus_i.col, tbl[i].col);
      check($sformatf("tbl%0d_busy", i), bus_i.busy, tbl[i].busy);
      check($sformatf("tbl%0d_frame_done", i), bus_i.frame_done, tbl[i].fd);
      check($sformatf("tbl%0d_load_ack", i), bus_i.load_ack, tbl[i].ack);
    end

    // Single frame: diagonal grid, row r shows col = 1<<r for DWELL cycles.
    drive(1'b1, 1'b0, 1'b0, 64'd0); step();
    drive(1'b0, 1'b1, 1'b0, DIAG);  step();
    drive(1'b0, 1'b0, 1'b1, 64'd0);
    for (int c = 1; c <= FRAME_P; c++) begin
      step();
      e = ((c - 1) % ROW_P < DWELL) ? (8'd1 << ((c - 1) / ROW_P)) : 8'h00;
      check("sf_row", bus_i.row, e);
      check("sf_col", bus_i.col, e);
      check("sf_frame_done", bus_i.frame_done, (c == FRAME_P));
    end

    // Tear-free update during row 3, then a bypass load on the frame_done cycle.
    drive(1'b1, 1'b0, 1'b0, 64'd0); step();
    drive(1'b0, 1'b1, 1'b0, 64'hFF00_0000_0000_0000); step();
    for (int c = 1; c <= 2 * FRAME_P; c++) begin
      if (c == 17) drive(1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_00FF);
      else         drive(1'b0, 1'b0, 1'b1, 64'd0);
      step();
      if (c >= 36 && c <= 39) check("tf_old_row7_col", bus_i.col, 8'hFF);
      if (c >= 41 && c <= 44) check("tf_new_row0_col", bus_i.col, 8'hFF);
      if (c >= 76 && c <= 79) check("tf_new_row7_col", bus_i.col, 8'h00);
    end
    check("bp_frame_done", bus_i.frame_done, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_0003); step();
    check("bp_row", bus_i.row, 8'h01);
    check("bp_col", bus_i.col, 8'h03);
    drive(1'b0, 1'b0, 1'b1, 64'd0); step();
    check("bp_col_hold", bus_i.col, 8'h03);

    // Enable drop in row 2: frame still completes, then idle.
    drive(1'b1, 1'b0, 1'b0, 64'd0); step();
    drive(1'b0, 1'b1, 1'b0, ONES);  step();
    drive(1'b0, 1'b0, 1'b1, 64'd0);
    for (int c = 1; c <= FRAME_P; c++) begin
      if (c == 12) drive(1'b0, 1'b0, 1'b0, 64'd0);
      step();
    end
    check("ed_frame_done", bus_i.frame_done, 1'b1);
    for (int c = 0; c < 4; c++) begin
      step();
      check("ed_busy", bus_i.busy, 1'b0);
      check("ed_row", bus_i.row, 8'h00);
    end

    // Reset during row 5 clears everything, including the displayed buffer.
    drive(1'b0, 1'b1, 1'b0, ONES); step();
    drive(1'b0, 1'b0, 1'b1, 64'd0);
    for (int c = 1; c <= 27; c++) step();
    check("rm_row5_before", bus_i.row, 8'h20);
    drive(1'b1, 1'b0, 1'b1, 64'd0); step();
    check("rm_row", bus_i.row, 8'h00);
    check("rm_busy", bus_i.busy, 1'b0);
    check("rm_frame_done", bus_i.frame_done, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 64'd0); step();
    check("rm_idle_row", bus_i.row, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 64'd0); step();
    check("rm_restart_row", bus_i.row, 8'h01);
    check("rm_restart_col", bus_i.col, 8'h00);

    // Random traffic against the model.
    en_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) en_r = ~en_r;
      drive(($urandom_range(0, 399) == 0), ($urandom_range(0, 5) == 0), en_r,
            {$urandom, $urandom});
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
